// File: rtl/alu_issue_queue.sv
// Valid/ready issue queue that feeds the combinational ALU from a DEPTH-entry FIFO, one op per cycle.
// Result is registered one edge after issue; in_ready drops only when full; a stalled output holds its value.
module alu_issue_queue #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_command,
   input  logic [SIZE-1:0]        in_a,
   input  logic [SIZE-1:0]        in_b,
   output logic                   alu_enable,
   output logic [3:0]             alu_command,
   output logic [SIZE-1:0]        alu_a,
   output logic [SIZE-1:0]        alu_b,
   input  logic                   alu_overflow,
   input  logic [2*SIZE-1:0]      alu_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*SIZE-1:0]      out_result,
   output logic                   out_overflow,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [3:0]      cmd;
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            out_valid_q, out_valid_d;
   logic [2*SIZE-1:0] out_result_q, out_result_d;
   logic            out_overflow_q, out_overflow_d;
   logic            out_illegal_q, out_illegal_d;

   entry_t head;
   logic   head_illegal;
   logic   push;
   logic   issue;

   assign head         = mem_q[rd_ptr_q];
   assign head_illegal = (head.cmd >= 4'd12);
   // in_ready looks only at registered occupancy, so a same-cycle pop never frees a slot
   assign in_ready     = (count_q != FULL);
   assign push         = in_valid && in_ready;
   assign issue        = (count_q != '0) && (!out_valid_q || out_ready);

   assign count        = count_q;
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_overflow = out_overflow_q;
   assign out_illegal  = out_illegal_q;

   always_comb begin
      alu_enable  = 1'b0;
      alu_command = '0;
      alu_a       = '0;
      alu_b       = '0;
      if (issue && !head_illegal) begin
         alu_enable  = 1'b1;
         alu_command = head.cmd;
         alu_a       = head.a;
         alu_b       = head.b;
      end
   end

   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      out_valid_d    = out_valid_q;
      out_result_d   = out_result_q;
      out_overflow_d = out_overflow_q;
      out_illegal_d  = out_illegal_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (issue) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         out_valid_d = 1'b1;
         if (head_illegal) begin
            out_result_d   = '0;
            out_overflow_d = 1'b0;
            out_illegal_d  = 1'b1;
         end else begin
            out_result_d   = alu_result;
            out_overflow_d = alu_overflow;
            out_illegal_d  = 1'b0;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      case ({push, issue})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         out_valid_q    <= 1'b0;
         out_result_q   <= '0;
         out_overflow_q <= 1'b0;
         out_illegal_q  <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         out_valid_q    <= out_valid_d;
         out_result_q   <= out_result_d;
         out_overflow_q <= out_overflow_d;
         out_illegal_q  <= out_illegal_d;
      end
   end

   // Storage needs no reset: entries are only visible through the reset pointers and count
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_command, in_a, in_b};
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_issue_queue;
   localparam int SIZE  = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_command = '0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        alu_enable;
   logic [3:0]  alu_command;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_overflow;
   logic [15:0] alu_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_result;
   logic        out_overflow;
   logic        out_illegal;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_issue_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command), .in_a(in_a), .in_b(in_b),
      .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
      .alu_overflow(alu_overflow), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_overflow(out_overflow), .out_illegal(out_illegal), .count(count)
   );

   function automatic logic [16:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] r;
      logic        o;
      r = '0;
      o = 1'b0;
      case (c)
         4'd0: r = {8'h00, a & b};
         4'd1: r = {8'h00, a | b};
         4'd2: r = {8'h00, a ^ b};
         4'd3: r = {8'h00, ~a};
         4'd4: begin r = 16'(a) + 16'(b); o = r[8]; end
         4'd5: begin r = {8'h00, a - b}; o = (a < b); end
         4'd6: begin r = 16'(a) * 16'(b); o = |r[15:8]; end
         default: begin r = {a, b} ^ {c, 12'h5A5}; o = c[0]; end
      endcase
      return {o, r};
   endfunction

   // ALU stand-in; a disabled ALU emits junk so illegal ops must be masked by the queue
   logic [16:0] alu_resp;
   always_comb begin
      if (alu_enable) alu_resp = alu_fn(alu_command, alu_a, alu_b);
      else            alu_resp = {1'b1, 16'hBEEF};
   end
   assign alu_overflow = alu_resp[16];
   assign alu_result   = alu_resp[15:0];

   typedef struct packed {
      logic [3:0] cmd;
      logic [7:0] a;
      logic [7:0] b;
   } op_t;

   op_t         mq[$];
   logic        m_vld = 1'b0;
   logic [15:0] m_res = '0;
   logic        m_ovf = 1'b0;
   logic        m_ill = 1'b0;
   logic        m_push, m_issue;
   op_t         m_head;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_vld = 1'b0; m_res = '0; m_ovf = 1'b0; m_ill = 1'b0;
      end else begin
         m_push  = in_valid && (mq.size() < DEPTH);
         m_issue = (mq.size() > 0) && (!m_vld || out_ready);
         if (m_issue) begin
            m_head = mq.pop_front();
            m_vld  = 1'b1;
            if (m_head.cmd >= 4'd12) begin
               m_res = '0; m_ovf = 1'b0; m_ill = 1'b1;
            end else begin
               {m_ovf, m_res} = alu_fn(m_head.cmd, m_head.a, m_head.b);
               m_ill = 1'b0;
            end
         end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
         end
         if (m_push) mq.push_back({in_command, in_a, in_b});
      end
   end

   task automatic drive_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1; in_command = c; in_a = a; in_b = b;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_result !== 16'h0000) begin n_bad++; $display("FAIL reset_out_result: got %h want 0000", out_result); end
      n_cmp++; if (alu_enable !== 1'b0) begin n_bad++; $display("FAIL reset_alu_enable: got %b want 0", alu_enable); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive_op(4'd0, 8'hF0, 8'h3C);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", count); end
      n_cmp++; if ({alu_enable, alu_command, alu_a, alu_b} !== {1'b1, 4'd0, 8'hF0, 8'h3C}) begin
         n_bad++; $display("FAIL basic_alu_drive: got %b/%h/%h/%h want 1/0/f0/3c", alu_enable, alu_command, alu_a, alu_b); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      @(negedge clk);
      n_cmp++; if ({out_valid, out_result, out_overflow, out_illegal} !== {1'b1, 16'h0030, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL basic_result: got v=%b r=%h o=%b i=%b want v=1 r=0030 o=0 i=0", out_valid, out_result, out_overflow, out_illegal); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive_op(4'd13, 8'hFF, 8'hFF);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if ({alu_enable, alu_command, alu_a, alu_b} !== 21'd0) begin
         n_bad++; $display("FAIL illegal_alu_drive: got %b/%h/%h/%h want all 0", alu_enable, alu_command, alu_a, alu_b); end
      @(negedge clk);
      n_cmp++; if ({out_valid, out_result, out_overflow, out_illegal} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL illegal_result: got v=%b r=%h o=%b i=%b want v=1 r=0000 o=0 i=1", out_valid, out_result, out_overflow, out_illegal); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL illegal_popped: got %0d want 0", count); end
      @(negedge clk);
   endtask

   task automatic test_stream();
      int sent, got;
      sent = 0; got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (sent < 10) begin drive_op(4'd1, 8'(sent), 8'h80); sent++; end
         else in_valid = 1'b0;
         @(negedge clk);
         if (out_valid) begin
            n_cmp++; if (out_result !== (16'h0080 | 16'(got))) begin
               n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", got, out_result, 16'h0080 | 16'(got)); end
            got++;
         end else if (got > 0 && got < 10) begin
            n_cmp++; n_bad++; $display("FAIL stream_gap: got out_valid=0 want 1 after %0d results", got);
         end
      end
      n_cmp++; if (got != 10) begin n_bad++; $display("FAIL stream_total: got %0d want 10", got); end
   endtask

   task automatic test_backpressure();
      op_t         ops[6];
      int          k, got;
      logic        rdy_seen;
      logic [16:0] e;
      for (int i = 0; i < 6; i++) ops[i] = {4'($urandom_range(0, 11)), 8'($urandom), 8'($urandom)};
      out_ready = 1'b0;
      k = 0;
      drive_op(ops[0].cmd, ops[0].a, ops[0].b);
      for (int c = 0; c < 11; c++) begin
         rdy_seen = in_ready;
         @(negedge clk);
         if (in_valid && rdy_seen) begin
            k++;
            if (k < 6) drive_op(ops[k].cmd, ops[k].a, ops[k].b); else in_valid = 1'b0;
         end
         if (c == 7) begin
            n_cmp++; if (k != 5) begin n_bad++; $display("FAIL bp_accepted: got %0d want 5", k); end
            n_cmp++; if ({count, in_ready} !== {3'd4, 1'b0}) begin
               n_bad++; $display("FAIL bp_full: got count=%0d in_ready=%b want 4/0", count, in_ready); end
         end
      end
      e = alu_fn(ops[0].cmd, ops[0].a, ops[0].b);
      n_cmp++; if ({out_valid, out_overflow, out_result} !== {1'b1, e}) begin
         n_bad++; $display("FAIL bp_hold: got v=%b o=%b r=%h want 1/%b/%h", out_valid, out_overflow, out_result, e[16], e[15:0]); end
      n_cmp++; if (k != 5) begin n_bad++; $display("FAIL bp_sixth_held: got %0d accepted want 5", k); end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 24 && got < 6; c++) begin
         if (out_valid) begin
            e = alu_fn(ops[got].cmd, ops[got].a, ops[got].b);
            n_cmp++; if ({out_overflow, out_result} !== e) begin
               n_bad++; $display("FAIL bp_drain[%0d]: got o=%b r=%h want o=%b r=%h", got, out_overflow, out_result, e[16], e[15:0]); end
            got++;
         end
         rdy_seen = in_ready;
         @(negedge clk);
         if (in_valid && rdy_seen) begin
            k++;
            if (k < 6) drive_op(ops[k].cmd, ops[k].a, ops[k].b); else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (got != 6 || k != 6) begin n_bad++; $display("FAIL bp_drain_total: got %0d out/%0d in want 6/6", got, k); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_full_pop();
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         drive_op(4'($urandom_range(0, 11)), 8'($urandom), 8'($urandom));
         @(negedge clk);
      end
      n_cmp++; if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL fp_full: got count=%0d in_ready=%b v=%b want 4/0/1", count, in_ready, out_valid); end
      out_ready = 1'b1;
      drive_op(4'd2, 8'h5A, 8'hA5);
      @(negedge clk);
      n_cmp++; if ({count, in_ready} !== {3'd3, 1'b1}) begin
         n_bad++; $display("FAIL fp_pop_no_push: got count=%0d in_ready=%b want 3/1", count, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fp_push_next: got count=%0d want 3", count); end
      for (int c = 0; c < 12 && (count != 0 || out_valid); c++) @(negedge clk);
      n_cmp++; if ({count, out_valid} !== {3'd0, 1'b0}) begin
         n_bad++; $display("FAIL fp_drain: got count=%0d v=%b want 0/0", count, out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      drive_op(4'd3, 8'h0F, 8'h00);
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++; if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
         n_bad++; $display("FAIL rst_mid_immediate: got v=%b count=%0d rdy=%b want 0/0/1", out_valid, count, in_ready); end
      @(negedge clk);
      n_cmp++; if ({count, in_ready} !== {3'd0, 1'b1}) begin
         n_bad++; $display("FAIL rst_mid_held: got count=%0d rdy=%b want 0/1", count, in_ready); end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ghost: got v=%b want 0 at cycle %0d", out_valid, c); end
      end
   endtask

   task automatic test_random();
      logic exp_en, exp_rdy;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         exp_rdy = (mq.size() != DEPTH);
         exp_en  = 1'b0;
         if (mq.size() != 0) exp_en = (!m_vld || out_ready) && (mq[0].cmd < 4'd12);
         n_cmp++; if (count !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, count, mq.size()); end
         n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, exp_rdy); end
         n_cmp++; if (out_valid !== m_vld) begin n_bad++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, m_vld); end
         n_cmp++; if ({out_result, out_overflow, out_illegal} !== {m_res, m_ovf, m_ill}) begin
            n_bad++; $display("FAIL rnd_out_data@%0d: got %h/%b/%b want %h/%b/%b", c, out_result, out_overflow, out_illegal, m_res, m_ovf, m_ill); end
         n_cmp++; if (alu_enable !== exp_en) begin n_bad++; $display("FAIL rnd_alu_enable@%0d: got %b want %b", c, alu_enable, exp_en); end
         if (exp_en) begin
            n_cmp++; if ({alu_command, alu_a, alu_b} !== mq[0]) begin
               n_bad++; $display("FAIL rnd_alu_fields@%0d: got %h/%h/%h want %h/%h/%h", c, alu_command, alu_a, alu_b, mq[0].cmd, mq[0].a, mq[0].b); end
         end
         in_valid   = ($urandom_range(0, 3) != 0);
         in_command = 4'($urandom_range(0, 15));
         in_a       = 8'($urandom);
         in_b       = 8'($urandom);
         out_ready  = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_stream();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
